bcd_seq_converter: RTL and testbench

Sequential binary-to-BCD converter controller using the shift-add-3 (double-dabble) algorithm, one iteration per clock.
- Accepts an unsigned binary word over a valid/ready handshake and returns packed BCD digits over a second valid/ready handshake.
- Covers the full input range: 0-255 at default width, hundreds digit included.
- Sits between the value-producing logic and the seven-segment display path.

---
 rtl/bcd_seq_converter.sv | 115 +++++++++++
 tb/tb_bcd_seq_converter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one iteration per clock.
// Optional range flag on out_range_err when BCD_RANGE_CHECK_EN is defined.
module bcd_seq_converter #(
   parameter int WIDTH   = 8,
   parameter int DIGITS  = 3,
   parameter int MAX_VAL = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  busy,
   output logic                  out_range_err
);

   localparam int BW = 4 * DIGITS;
   localparam int SW = BW + WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [SW-1:0] r_shift;
   logic [SW-1:0] w_corr;
   logic [SW-1:0] w_shifted;
   logic [CW-1:0] r_cnt;
   logic [BW-1:0] r_bcd;
   logic          w_accept;
   logic          w_last;

   assign w_accept  = (r_state == IDLE) && in_valid;
   assign w_last    = (r_cnt == CW'(1));
   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state == SHIFT);
   assign out_valid = (r_state == DONE);
   assign out_bcd   = r_bcd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (in_valid)  w_next = SHIFT;
         SHIFT:   if (w_last)    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Correct every BCD nibble before the shift so both land on one edge.
   always_comb begin
      w_corr = r_shift;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_shift[WIDTH+4*d +: 4] >= 4'd5) begin
            w_corr[WIDTH+4*d +: 4] = r_shift[WIDTH+4*d +: 4] + 4'd3;
         end
      end
   end

   assign w_shifted = {w_corr[SW-2:0], 1'b0};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
      end else if (w_accept) begin
         r_shift <= {{BW{1'b0}}, in_data};
         r_cnt   <= CW'(WIDTH);
      end else if (r_state == SHIFT) begin
         r_shift <= w_shifted;
         r_cnt   <= r_cnt - 1'b1;
         if (w_last) begin
            r_bcd <= w_shifted[SW-1 -: BW];
         end
      end
   end

`ifdef BCD_RANGE_CHECK_EN
   logic r_range_err;
   logic w_over;

   assign w_over = ({{(32-WIDTH){1'b0}}, in_data} > $unsigned(MAX_VAL));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_range_err <= 1'b0;
      end else if (w_accept) begin
         r_range_err <= w_over;
      end else if ((r_state == DONE) && out_ready) begin
         r_range_err <= 1'b0;
      end
   end

   assign out_range_err = r_range_err && (r_state == DONE);
`else
   assign out_range_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: directed vectors plus a 0-255 sweep.
// Expected results are queued at issue time and popped by a monitor.
module tb_bcd_seq_converter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [11:0] out_bcd;
   logic        busy;
   logic        out_range_err;

   int checks = 0;
   int failures = 0;
   logic [12:0] sb_q[$];
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;

   bcd_seq_converter #(.WIDTH(8), .DIGITS(3), .MAX_VAL(99)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_bcd(out_bcd),
      .busy(busy),
      .out_range_err(out_range_err)
   );

   function automatic logic [11:0] ref_bcd(input int v);
      logic [3:0] h, t, u;
      h = 4'((v / 100) % 10);
      t = 4'((v / 10) % 10);
      u = 4'(v % 10);
      return {h, t, u};
   endfunction

   function automatic logic exp_err(input int v);
`ifdef BCD_RANGE_CHECK_EN
      return (v > 99);
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: one pop per presented result (rising out_valid).
   always @(negedge clk) begin
      if (reset) begin
         prev_valid <= 1'b0;
      end else begin
         prev_valid <= out_valid;
         if (out_valid && !prev_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_result actual=%0h required=none", out_bcd);
            end else begin
               logic [12:0] e;
               e = sb_q.pop_front();
               if ({out_range_err, out_bcd} !== e) begin
                  failures++;
                  $display("FAIL result actual=%0h/%0h required=%0h/%0h",
                           out_range_err, out_bcd, e[12], e[11:0]);
               end
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic convert(input int v, input logic [11:0] exp);
      wait_ready();
      in_valid = 1'b1;
      in_data = 8'(v);
      sb_q.push_back({exp_err(v), exp});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   initial begin
      int cyc;
      int bad;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_bcd", 32'(out_bcd), 32'd0);
      check("rst_range_err", 32'(out_range_err), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Latency of a conversion of 0.
      convert(0, 12'h000);
      check("acc_in_ready", 32'(in_ready), 32'd0);
      check("acc_busy", 32'(busy), 32'd1);
      cyc = 0;
      bad = 0;
      while (!out_valid && cyc < 20) begin
         if (!busy) bad++;
         @(posedge clk);
         #1;
         cyc++;
      end
      check("latency", 32'(cyc), 32'd8);
      check("busy_through_shift", 32'(bad), 32'd0);

      convert(255, 12'h255);
      convert(99, 12'h099);
      convert(100, 12'h100);
      convert(9, 12'h009);
      for (int v = 0; v < 256; v++) convert(v, ref_bcd(v));

      // Backpressure hold.
      wait_ready();
      out_ready = 1'b0;
      convert(173, 12'h173);
      wait_valid();
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (!out_valid || out_bcd !== 12'h173 || in_ready) bad++;
         @(posedge clk);
         #1;
      end
      check("bp_stable", 32'(bad), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      check("bp_bcd_held", 32'(out_bcd), 32'h173);

      // in_valid held during a conversion is not queued.
      wait_ready();
      in_valid = 1'b1;
      in_data = 8'd200;
      sb_q.push_back({exp_err(200), 12'h200});
      @(posedge clk);
      #1;
      in_data = 8'd42;
      sb_q.push_back({exp_err(42), 12'h042});
      wait_ready();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("held_busy", 32'(busy), 32'd1);

      // Reset mid-conversion.
      wait_ready();
      in_valid = 1'b1;
      in_data = 8'd250;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_out_bcd", 32'(out_bcd), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      convert(7, 12'h007);

      // Range flag (asserted only when the feature is built in).
      convert(100, 12'h100);
      convert(99, 12'h099);
      convert(255, 12'h255);

      cyc = 0;
      while (sb_q.size() != 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
